prio_arbiter: RTL and testbench

Parametrised, registered successor to the team's 8-to-3 combinational priority encoder. Takes N request lines and produces a one-hot grant plus a binary index, held behind a valid/ready output handshake. It supports fixed priority (highest index wins) and round-robin modes. It sits between request sources and any downstream consumer that must be able to stall.

---
 rtl/prio_arbiter.sv | 117 +++++++++++
 tb/tb_prio_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// Registered N-way priority arbiter with a valid/ready output stage.
// mode=0 grants the highest set request index. mode=1 is round-robin,
// starting the search at a pointer that advances past each accepted grant.
module prio_arbiter #(
  parameter  int N      = 8,
  localparam int CODE_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [N-1:0]      req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] code,
  output logic [N-1:0]      grant,
  output logic              none
);

  localparam logic [CODE_W-1:0] LAST = CODE_W'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] ptr, ptr_d;
  logic              last_mode, last_mode_d;
  logic [CODE_W-1:0] code_d;
  logic [N-1:0]      grant_d;
  logic              none_d;

  logic              loadable, handshake;
  logic [CODE_W-1:0] ptr_adv, search_ptr;
  logic [CODE_W-1:0] fx_code, rr_code;
  logic              rr_found;
  int                rr_idx;

  assign out_valid = (state_q == VALID);

  // Work out the pointer the round-robin search starts from for this load.
  // A mode change since the previous load restarts the rotation at index 0.
  always_comb begin
    loadable  = (state_q == IDLE) || out_ready;
    handshake = (state_q == VALID) && out_ready;
    ptr_adv   = ptr;
    if (handshake) begin
      ptr_adv = (code == LAST) ? '0 : code + CODE_W'(1);
    end
    search_ptr = (mode != last_mode) ? '0 : ptr_adv;
  end

  // Fixed-priority and round-robin winner selection over the live request vector.
  always_comb begin
    fx_code  = '0;
    rr_code  = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fx_code = CODE_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      rr_idx = int'(search_ptr) + i;
      if (rr_idx >= N) rr_idx = rr_idx - N;
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_code  = CODE_W'(rr_idx);
      end
    end
  end

  // Next-state and next-output logic; a stalled VALID stage holds everything.
  always_comb begin
    state_d     = state_q;
    code_d      = code;
    grant_d     = grant;
    none_d      = none;
    ptr_d       = ptr;
    last_mode_d = last_mode;
    if (loadable) begin
      ptr_d       = search_ptr;
      last_mode_d = mode;
      if (req == '0) begin
        state_d = IDLE;
        code_d  = '0;
        grant_d = '0;
        none_d  = 1'b1;
      end else begin
        state_d          = VALID;
        code_d           = mode ? rr_code : fx_code;
        grant_d          = '0;
        grant_d[code_d]  = 1'b1;
        none_d           = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code      <= '0;
      grant     <= '0;
      none      <= 1'b1;
      ptr       <= '0;
      last_mode <= 1'b0;
    end else begin
      state_q   <= state_d;
      code      <= code_d;
      grant     <= grant_d;
      none      <= none_d;
      ptr       <= ptr_d;
      last_mode <= last_mode_d;
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter: an N=8 and an N=5 instance, each
// tracked by a behavioural model built from the arbitration rules.
module tb_prio_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mode, out_ready;
  logic [7:0] req;
  logic       out_valid;
  logic [2:0] code;
  logic [7:0] grant;
  logic       none;

  logic       rst5, mode5, ready5;
  logic [4:0] req5;
  logic       valid5;
  logic [2:0] code5;
  logic [4:0] grant5;
  logic       none5;

  prio_arbiter #(.N(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .code(code), .grant(grant), .none(none)
  );

  prio_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst(rst5), .mode(mode5), .req(req5), .out_ready(ready5),
    .out_valid(valid5), .code(code5), .grant(grant5), .none(none5)
  );

  int checks = 0;
  int passed = 0;

  // Model state per instance: [0] is N=8, [1] is N=5.
  bit m_valid[2] = '{0, 0};
  int m_code[2]  = '{0, 0};
  bit m_none[2]  = '{1, 1};
  int m_ptr[2]   = '{0, 0};
  bit m_mode[2]  = '{0, 0};

  function automatic int pick(int n, bit md, logic [7:0] rq, int p);
    int w = -1;
    if (!md) begin
      for (int i = 0; i < n; i++) if (rq[i]) w = i;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (w < 0 && rq[(p + i) % n]) w = (p + i) % n;
      end
    end
    return w;
  endfunction

  task automatic model_step(int k, int n, bit r, bit md, logic [7:0] rq, bit rdy);
    int p;
    if (r) begin
      m_valid[k] = 0; m_code[k] = 0; m_none[k] = 1; m_ptr[k] = 0; m_mode[k] = 0;
    end else if (!m_valid[k] || rdy) begin
      p = m_ptr[k];
      if (m_valid[k] && rdy) p = (m_code[k] + 1) % n;
      if (md != m_mode[k]) p = 0;
      m_ptr[k]  = p;
      m_mode[k] = md;
      if (rq == 8'h00) begin
        m_valid[k] = 0; m_code[k] = 0; m_none[k] = 1;
      end else begin
        m_valid[k] = 1; m_none[k] = 0; m_code[k] = pick(n, md, rq, p);
      end
    end
  endtask

  function automatic logic [12:0] exp_vec(int k);
    logic [7:0] g;
    g = '0;
    if (m_valid[k]) g[m_code[k]] = 1'b1;
    return {m_valid[k], 3'(m_code[k]), g, m_none[k]};
  endfunction

  task automatic tick();
    model_step(0, 8, rst, mode, req, out_ready);
    model_step(1, 5, rst5, mode5, {3'b000, req5}, ready5);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; rst5 = 1;
    tick(); tick();
    checks++;
    if ({out_valid, code, grant, none} !== {1'b0, 3'd0, 8'h00, 1'b1})
      $display("FAIL reset8: got %h expected %h", {out_valid, code, grant, none}, {1'b0, 3'd0, 8'h00, 1'b1});
    else passed++;
    checks++;
    if ({valid5, code5, grant5, none5} !== {1'b0, 3'd0, 5'h00, 1'b1})
      $display("FAIL reset5: got %h expected %h", {valid5, code5, grant5, none5}, {1'b0, 3'd0, 5'h00, 1'b1});
    else passed++;
    rst = 0; rst5 = 0;
  endtask

  task automatic test_fixed_sweep();
    mode = 0; out_ready = 1;
    for (int v = 1; v < 256; v++) begin
      req = 8'(v);
      tick();
      checks++;
      if ({out_valid, code, grant, none} !== exp_vec(0))
        $display("FAIL fixed_sweep req=%h: got %h expected %h", req, {out_valid, code, grant, none}, exp_vec(0));
      else passed++;
    end
    checks++;
    if ({out_valid, code, grant} !== {1'b1, 3'd7, 8'h80})
      $display("FAIL fixed_top: got %h expected %h", {out_valid, code, grant}, {1'b1, 3'd7, 8'h80});
    else passed++;
  endtask

  task automatic test_rr_fairness();
    int seq1[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int seq2[4]  = '{7, 1, 7, 1};
    mode = 1; out_ready = 1; req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({out_valid, code, grant, none} !== exp_vec(0) || code !== 3'(seq1[i]))
        $display("FAIL rr_ff step %0d: got code %0d expected %0d", i, code, seq1[i]);
      else passed++;
    end
    req = 8'b1000_0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({out_valid, code, grant, none} !== exp_vec(0) || code !== 3'(seq2[i]))
        $display("FAIL rr_82 step %0d: got code %0d expected %0d", i, code, seq2[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    rst = 1; tick(); rst = 0;
    mode = 1; req = 8'h0C; out_ready = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) req = 8'h01;
      tick();
      checks++;
      if ({out_valid, code, grant, none} !== {1'b1, 3'd2, 8'h04, 1'b0} ||
          {out_valid, code, grant, none} !== exp_vec(0))
        $display("FAIL stall %0d: got %h expected %h", i, {out_valid, code, grant, none}, {1'b1, 3'd2, 8'h04, 1'b0});
      else passed++;
    end
    req = 8'h0C; out_ready = 1;
    tick();
    checks++;
    if ({out_valid, code, grant} !== {1'b1, 3'd3, 8'h08} || {out_valid, code, grant, none} !== exp_vec(0))
      $display("FAIL release: got %h expected %h", {out_valid, code, grant}, {1'b1, 3'd3, 8'h08});
    else passed++;
  endtask

  task automatic test_empty();
    out_ready = 1; req = 8'h00;
    tick();
    checks++;
    if ({out_valid, code, grant, none} !== {1'b0, 3'd0, 8'h00, 1'b1})
      $display("FAIL empty: got %h expected %h", {out_valid, code, grant, none}, {1'b0, 3'd0, 8'h00, 1'b1});
    else passed++;
    req = 8'h10;
    tick();
    checks++;
    if ({out_valid, code, grant, none} !== {1'b1, 3'd4, 8'h10, 1'b0})
      $display("FAIL after_empty: got %h expected %h", {out_valid, code, grant, none}, {1'b1, 3'd4, 8'h10, 1'b0});
    else passed++;
  endtask

  task automatic test_midreset_mode();
    rst = 1; tick(); rst = 0;
    mode = 1; req = 8'hFF; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (code !== 3'(i) || {out_valid, code, grant, none} !== exp_vec(0))
        $display("FAIL mid_rr %0d: got code %0d expected %0d", i, code, i);
      else passed++;
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({out_valid, code, grant, none} !== {1'b0, 3'd0, 8'h00, 1'b1})
      $display("FAIL mid_reset: got %h expected %h", {out_valid, code, grant, none}, {1'b0, 3'd0, 8'h00, 1'b1});
    else passed++;
    tick();
    checks++;
    if (code !== 3'd0 || out_valid !== 1'b1)
      $display("FAIL ptr_cleared: got code %0d expected 0", code);
    else passed++;
    mode = 0; req = 8'h08;
    tick();
    checks++;
    if (code !== 3'd3)
      $display("FAIL fixed_08: got code %0d expected 3", code);
    else passed++;
    mode = 1; req = 8'h81;
    tick();
    checks++;
    if ({out_valid, code, grant} !== {1'b1, 3'd0, 8'h01} || {out_valid, code, grant, none} !== exp_vec(0))
      $display("FAIL mode_switch: got code %0d expected 0", code);
    else passed++;
  endtask

  task automatic test_npot();
    rst5 = 1; tick(); rst5 = 0;
    mode5 = 1; req5 = 5'b11111; ready5 = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (code5 !== 3'(i % 5) || {valid5, code5, 3'b000, grant5, none5} !== exp_vec(1))
        $display("FAIL npot %0d: got code %0d expected %0d", i, code5, i % 5);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mode      = ($urandom_range(0, 9) == 0) ? ~mode : mode;
      req       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst5      = ($urandom_range(0, 59) == 0);
      mode5     = ($urandom_range(0, 9) == 0) ? ~mode5 : mode5;
      req5      = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
      ready5    = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if ({out_valid, code, grant, none} !== exp_vec(0))
        $display("FAIL random8 %0d: got %h expected %h", i, {out_valid, code, grant, none}, exp_vec(0));
      else passed++;
      checks++;
      if ({valid5, code5, 3'b000, grant5, none5} !== exp_vec(1))
        $display("FAIL random5 %0d: got %h expected %h", i, {valid5, code5, 3'b000, grant5, none5}, exp_vec(1));
      else passed++;
    end
  endtask

  initial begin
    rst = 1; mode = 0; req = '0; out_ready = 0;
    rst5 = 1; mode5 = 0; req5 = '0; ready5 = 0;
    test_reset();
    test_fixed_sweep();
    test_rr_fairness();
    test_backpressure();
    test_empty();
    test_midreset_mode();
    test_npot();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
